// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit that owns the architectural HI/LO pair.
//
// Multiply is shift-add over the magnitudes of the operands. Divide is restoring
// division over the magnitudes. Both take ITERS datapath cycles (CALC). One sign-fix
// cycle (FINAL) follows, and HI/LO are written at the end of FINAL. mthi/mtlo write
// directly from IDLE.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (beats flush and start)
//   start     EX presents an op this cycle (qualifies op_i/regaData/regbData)
//   op_i      6-bit function code: mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//   regaData  rs operand: multiplicand / dividend / mthi-mtlo source
//   regbData  rt operand: multiplier / divisor
//   flush     abort any in-flight op; HI/LO keep their pre-op values
//   busy      op in CALC or FINAL (registered)
//   done      one-cycle pulse during FINAL of mult/div (registered)
//   stall_req hold ID/EX (combinational)
//   HI, LO    architectural HI/LO (registered)
//
// Handshake: an op is taken only when start=1 in IDLE with no flush. While busy,
// stall_req is high and any start is ignored. EX keeps presenting the op until
// stall_req drops, and it is taken at the first edge where stall_req is low.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op_i,
    input  logic [WIDTH-1:0] regaData,
    input  logic [WIDTH-1:0] regbData,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    // MIPS SPECIAL function codes
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated (dividend was negative)
    logic               div_zero;

    // ---------------- operand decode ----------------
    logic             op_mul, op_div, op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
        op_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
        op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
        a_neg     = op_signed && regaData[WIDTH-1];
        b_neg     = op_signed && regbData[WIDTH-1];
        abs_a     = a_neg ? (~regaData + 1'b1) : regaData;
        abs_b     = b_neg ? (~regbData + 1'b1) : regbData;
    end

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Add the multiplicand into the high half when the current multiplier bit
        // is set, then shift the whole pair right; the carry lands in bit 2*WIDTH-1.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Bring the next dividend bit into the remainder and try the subtraction.
        // A set borrow bit means the trial went negative, so keep the shifted value.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // ---------------- sign fix for commit ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_raw, r_raw;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        q_raw    = acc[WIDTH-1:0];
        r_raw    = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            // A zero divisor leaves an all-ones quotient magnitude; the signed
            // sign fix would distort it, so it is forced back to all ones.
            if (div_zero)
                fin_lo = '1;
            else
                fin_lo = neg_res ? (~q_raw + 1'b1) : q_raw;
            fin_hi = neg_rem ? (~r_raw + 1'b1) : r_raw;
        end else begin
            fin_lo = prod_fix[WIDTH-1:0];
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // Both stall causes (an active op, or an HI/LO access arriving while busy)
    // reduce to busy, which already covers FINAL.
    assign stall_req = busy;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (op_mul || op_div) begin
                            is_div   <= op_div;
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= op_div && (regbData == '0);
                            if (op_div) begin
                                acc  <= {{WIDTH{1'b0}}, abs_a};
                                opnd <= abs_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, abs_b};
                                opnd <= abs_a;
                            end
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end else if (op_i == OP_MTHI) begin
                            HI <= regaData;
                        end else if (op_i == OP_MTLO) begin
                            LO <= regaData;
                        end
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt == CNT_LAST) begin
                        state <= S_FINAL;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FINAL: begin
                    HI    <= fin_hi;
                    LO    <= fin_lo;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
